// File: rtl/complex_nr_mult_initiator_pkg.sv
// Shared definitions for the complex multiplier initiator: FSM encoding
// and small handshake helpers.
package complex_nr_mult_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic HS_ASSERT   = 1'b1;
  localparam logic HS_DEASSERT = 1'b0;

  // A transfer happens when valid and ready are both high at the same edge.
  function automatic logic xfer(input logic val, input logic ready);
    return val & ready;
  endfunction

endpackage

// File: rtl/complex_nr_mult_initiator_acc.sv
// Complex accumulator: two signed wrapping accumulators, a saturating term
// counter and a sticky signed-overflow flag, with clear priority over enable.
module complex_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    en,
  input  logic [2*DATA_WIDTH-1:0] prod_re,
  input  logic [2*DATA_WIDTH-1:0] prod_im,
  output logic [ACC_WIDTH-1:0]    acc_re,
  output logic [ACC_WIDTH-1:0]    acc_im,
  output logic [CNT_WIDTH-1:0]    acc_cnt,
  output logic                    acc_ovf
);

  logic [ACC_WIDTH-1:0] ext_re, ext_im;
  logic [ACC_WIDTH-1:0] sum_re, sum_im;
  logic                 ovf_re, ovf_im;

  // Sign-extend the products, form wrapped sums and detect signed overflow
  // (addends share a sign but the sum's sign differs).
  always_comb begin
    ext_re = ACC_WIDTH'($signed(prod_re));
    ext_im = ACC_WIDTH'($signed(prod_im));
    sum_re = acc_re + ext_re;
    sum_im = acc_im + ext_im;
    ovf_re = (acc_re[ACC_WIDTH-1] == ext_re[ACC_WIDTH-1]) &&
             (sum_re[ACC_WIDTH-1] != acc_re[ACC_WIDTH-1]);
    ovf_im = (acc_im[ACC_WIDTH-1] == ext_im[ACC_WIDTH-1]) &&
             (sum_im[ACC_WIDTH-1] != acc_im[ACC_WIDTH-1]);
  end

  // Accumulator state: clear wins, otherwise add one term per enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_re  <= '0;
      acc_im  <= '0;
      acc_cnt <= '0;
      acc_ovf <= 1'b0;
    end else if (clr) begin
      acc_re  <= '0;
      acc_im  <= '0;
      acc_cnt <= '0;
      acc_ovf <= 1'b0;
    end else if (en) begin
      acc_re  <= sum_re;
      acc_im  <= sum_im;
      if (acc_cnt != '1) acc_cnt <= acc_cnt + 1'b1;
      acc_ovf <= acc_ovf | ovf_re | ovf_im;
    end
  end

endmodule

// File: rtl/complex_nr_mult_initiator.sv
// Initiator for a complex multiplier: takes operand pairs from a host stream,
// issues them one at a time to the multiplier, accumulates the products over
// a burst ending at in_last and presents the complex dot product.
//
// Handshakes: every port transfers on a posedge where its val and ready are
// both high; val is never withdrawn before the transfer and data under a
// high val is held stable until that transfer.
module complex_nr_mult_initiator
  import complex_nr_mult_initiator_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sw_rst,
  input  logic                    in_val,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [DATA_WIDTH-1:0]   in_op_1_re,
  input  logic [DATA_WIDTH-1:0]   in_op_1_im,
  input  logic [DATA_WIDTH-1:0]   in_op_2_re,
  input  logic [DATA_WIDTH-1:0]   in_op_2_im,
  output logic                    mult_op_val,
  input  logic                    mult_op_ready,
  output logic [DATA_WIDTH-1:0]   mult_op_1_re,
  output logic [DATA_WIDTH-1:0]   mult_op_1_im,
  output logic [DATA_WIDTH-1:0]   mult_op_2_re,
  output logic [DATA_WIDTH-1:0]   mult_op_2_im,
  input  logic                    mult_res_val,
  output logic                    mult_res_ready,
  input  logic [2*DATA_WIDTH-1:0] mult_result_re,
  input  logic [2*DATA_WIDTH-1:0] mult_result_im,
  output logic                    acc_val,
  input  logic                    acc_ready,
  output logic [ACC_WIDTH-1:0]    acc_re,
  output logic [ACC_WIDTH-1:0]    acc_im,
  output logic [CNT_WIDTH-1:0]    acc_cnt,
  output logic                    acc_ovf,
  output state_t                  fsm_state
);

  state_t state, state_nxt;
  logic   last_q;
  logic   op_load;
  logic   res_xfer;
  logic   acc_xfer;

  assign fsm_state = state;

  // State register; software reset returns to IDLE ahead of any handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       state <= ST_IDLE;
    else if (sw_rst) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state and handshake outputs; each port is only ever ready/valid in
  // its own state, so one multiplier transaction is outstanding at a time.
  always_comb begin
    state_nxt      = state;
    in_ready       = HS_DEASSERT;
    mult_op_val    = HS_DEASSERT;
    mult_res_ready = HS_DEASSERT;
    acc_val        = HS_DEASSERT;
    op_load        = 1'b0;
    res_xfer       = 1'b0;
    acc_xfer       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = HS_ASSERT;
        if (xfer(in_val, in_ready)) begin
          op_load   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mult_op_val = HS_ASSERT;
        if (xfer(mult_op_val, mult_op_ready)) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        mult_res_ready = HS_ASSERT;
        if (xfer(mult_res_val, mult_res_ready)) begin
          res_xfer  = 1'b1;
          state_nxt = last_q ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        acc_val = HS_ASSERT;
        if (xfer(acc_val, acc_ready)) begin
          acc_xfer  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand registers feed the multiplier directly; they only load in IDLE,
  // so they hold from ISSUE entry through the WAIT exit edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mult_op_1_re <= '0;
      mult_op_1_im <= '0;
      mult_op_2_re <= '0;
      mult_op_2_im <= '0;
      last_q       <= 1'b0;
    end else if (sw_rst) begin
      mult_op_1_re <= '0;
      mult_op_1_im <= '0;
      mult_op_2_re <= '0;
      mult_op_2_im <= '0;
      last_q       <= 1'b0;
    end else if (op_load) begin
      mult_op_1_re <= in_op_1_re;
      mult_op_1_im <= in_op_1_im;
      mult_op_2_re <= in_op_2_re;
      mult_op_2_im <= in_op_2_im;
      last_q       <= in_last;
    end
  end

  complex_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_acc (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (sw_rst | acc_xfer),
    .en      (res_xfer),
    .prod_re (mult_result_re),
    .prod_im (mult_result_im),
    .acc_re  (acc_re),
    .acc_im  (acc_im),
    .acc_cnt (acc_cnt),
    .acc_ovf (acc_ovf)
  );

endmodule

// File: tb/tb_complex_nr_mult_initiator.sv
// Bench for complex_nr_mult_initiator: a 20-bit and a 16-bit accumulator
// instance share one host/multiplier stimulus; the bench plays both the
// host and the multiplier and scores each burst sum from its own model.
module tb_complex_nr_mult_initiator;
  import complex_nr_mult_initiator_pkg::*;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int CW = 8;

  typedef struct packed {
    logic [AW-1:0] re;
    logic [AW-1:0] im;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic [15:0]   re16;
    logic [15:0]   im16;
    logic          ovf16;
  } exp_t;
  localparam int EW = $bits(exp_t);

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sw_rst = 1'b0;
  logic in_val = 1'b0, in_last = 1'b0;
  logic [DW-1:0] in_op_1_re = '0, in_op_1_im = '0, in_op_2_re = '0, in_op_2_im = '0;
  logic mult_op_ready = 1'b0, mult_res_val = 1'b0, acc_ready = 1'b0;
  logic [2*DW-1:0] mult_result_re = '0, mult_result_im = '0;

  logic in_ready, mult_op_val, mult_res_ready, acc_val, acc_ovf;
  logic [DW-1:0] mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im;
  logic [AW-1:0] acc_re, acc_im;
  logic [CW-1:0] acc_cnt;
  state_t fsm_state;

  logic b_in_ready, b_mult_op_val, b_mult_res_ready, b_acc_val, b_acc_ovf;
  logic [DW-1:0] b_mult_op_1_re, b_mult_op_1_im, b_mult_op_2_re, b_mult_op_2_im;
  logic [15:0] b_acc_re, b_acc_im;
  logic [CW-1:0] b_acc_cnt;
  state_t b_fsm_state;

  always #5 clk = ~clk;

  complex_nr_mult_initiator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst),
    .in_val(in_val), .in_ready(in_ready), .in_last(in_last),
    .in_op_1_re(in_op_1_re), .in_op_1_im(in_op_1_im),
    .in_op_2_re(in_op_2_re), .in_op_2_im(in_op_2_im),
    .mult_op_val(mult_op_val), .mult_op_ready(mult_op_ready),
    .mult_op_1_re(mult_op_1_re), .mult_op_1_im(mult_op_1_im),
    .mult_op_2_re(mult_op_2_re), .mult_op_2_im(mult_op_2_im),
    .mult_res_val(mult_res_val), .mult_res_ready(mult_res_ready),
    .mult_result_re(mult_result_re), .mult_result_im(mult_result_im),
    .acc_val(acc_val), .acc_ready(acc_ready),
    .acc_re(acc_re), .acc_im(acc_im), .acc_cnt(acc_cnt), .acc_ovf(acc_ovf),
    .fsm_state(fsm_state)
  );

  complex_nr_mult_initiator #(.DATA_WIDTH(DW), .ACC_WIDTH(16), .CNT_WIDTH(CW)) dut16 (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst),
    .in_val(in_val), .in_ready(b_in_ready), .in_last(in_last),
    .in_op_1_re(in_op_1_re), .in_op_1_im(in_op_1_im),
    .in_op_2_re(in_op_2_re), .in_op_2_im(in_op_2_im),
    .mult_op_val(b_mult_op_val), .mult_op_ready(mult_op_ready),
    .mult_op_1_re(b_mult_op_1_re), .mult_op_1_im(b_mult_op_1_im),
    .mult_op_2_re(b_mult_op_2_re), .mult_op_2_im(b_mult_op_2_im),
    .mult_res_val(mult_res_val), .mult_res_ready(b_mult_res_ready),
    .mult_result_re(mult_result_re), .mult_result_im(mult_result_im),
    .acc_val(b_acc_val), .acc_ready(acc_ready),
    .acc_re(b_acc_re), .acc_im(b_acc_im), .acc_cnt(b_acc_cnt), .acc_ovf(b_acc_ovf),
    .fsm_state(b_fsm_state)
  );

  // ---------------- scoreboard / counters ----------------
  logic [EW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int op_hs = 0;
  int res_hs = 0;

  // Reference model of the running burst sum (values kept in signed range).
  int m_re = 0, m_im = 0, m_re16 = 0, m_im16 = 0, m_cnt = 0;
  logic m_ovf = 1'b0, m_ovf16 = 1'b0;

  // Handshake counters on the multiplier side of the main instance.
  always @(posedge clk) begin
    if (mult_op_val && mult_op_ready) op_hs <= op_hs + 1;
    if (mult_res_val && mult_res_ready) res_hs <= res_hs + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Complex product truncated to 2*DW bits: {re, im}.
  function automatic logic [31:0] cmul(input logic [7:0] ar, ai, br, bi);
    int a_r, a_i, b_r, b_i;
    a_r = $signed(ar); a_i = $signed(ai); b_r = $signed(br); b_i = $signed(bi);
    return {16'(a_r * b_r - a_i * b_i), 16'(a_r * b_i + a_i * b_r)};
  endfunction

  // Add one value to a model accumulator of width w, wrapping and flagging overflow.
  task automatic wrap_add(inout int acc, input logic [15:0] p, input int w, inout logic ovf);
    int s, lim;
    lim = 1 << (w - 1);
    s = acc + int'($signed(p));
    if (s > lim - 1) begin s = s - 2 * lim; ovf = 1'b1; end
    if (s < -lim)    begin s = s + 2 * lim; ovf = 1'b1; end
    acc = s;
  endtask

  task automatic model_clear();
    m_re = 0; m_im = 0; m_re16 = 0; m_im16 = 0; m_cnt = 0;
    m_ovf = 1'b0; m_ovf16 = 1'b0;
  endtask

  task automatic model_add(input logic [15:0] pre, input logic [15:0] pim);
    wrap_add(m_re, pre, AW, m_ovf);
    wrap_add(m_im, pim, AW, m_ovf);
    wrap_add(m_re16, pre, 16, m_ovf16);
    wrap_add(m_im16, pim, 16, m_ovf16);
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic model_push();
    exp_t e;
    e.re = AW'(m_re); e.im = AW'(m_im); e.cnt = CW'(m_cnt); e.ovf = m_ovf;
    e.re16 = 16'(m_re16); e.im16 = 16'(m_im16); e.ovf16 = m_ovf16;
    exp_q.push_back(EW'(e));
    model_clear();
  endtask

  // ---------------- driver tasks (all start and end at a negedge) ----------------
  task automatic do_term(input logic [7:0] ar, ai, br, bi, input logic last,
                         input int op_dly, input int res_dly);
    int n, op0, res0;
    logic [31:0] p, pm;
    op0 = op_hs; res0 = res_hs;
    in_op_1_re = ar; in_op_1_im = ai; in_op_2_re = br; in_op_2_im = bi;
    in_last = last; in_val = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready", in_ready, 1);
    @(negedge clk);
    in_val = 1'b0; in_last = 1'b0;
    in_op_1_re = ~ar; in_op_1_im = ~ai; in_op_2_re = ~br; in_op_2_im = ~bi;
    // ISSUE: stale result pulses while the multiplier is not yet engaged
    for (int i = 0; i <= op_dly; i++) begin
      chk("issue_state", fsm_state, ST_ISSUE);
      chk("issue_flags", {in_ready, mult_op_val, mult_res_ready, acc_val}, 4'b0100);
      chk("issue_ops", {mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im}, {ar, ai, br, bi});
      chk("b_issue_ops", {b_mult_op_1_re, b_mult_op_1_im, b_mult_op_2_re, b_mult_op_2_im}, {ar, ai, br, bi});
      chk("b_issue_flags", {b_in_ready, b_mult_op_val, b_mult_res_ready, b_acc_val}, 4'b0100);
      mult_res_val = (i < op_dly);
      mult_result_re = 16'h5a5a; mult_result_im = 16'ha5a5;
      mult_op_ready = (i == op_dly);
      @(negedge clk);
    end
    mult_op_ready = 1'b0; mult_res_val = 1'b0;
    // WAIT: stale op-ready pulses, then the multiplier answers
    pm = cmul(mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im);
    for (int i = 0; i <= res_dly; i++) begin
      chk("wait_state", fsm_state, ST_WAIT);
      chk("wait_flags", {in_ready, mult_op_val, mult_res_ready, acc_val}, 4'b0010);
      chk("wait_ops", {mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im}, {ar, ai, br, bi});
      mult_op_ready = (i < res_dly);
      mult_res_val = (i == res_dly);
      mult_result_re = pm[31:16]; mult_result_im = pm[15:0];
      @(negedge clk);
    end
    mult_res_val = 1'b0; mult_op_ready = 1'b0;
    p = cmul(ar, ai, br, bi);
    model_add(p[31:16], p[15:0]);
    chk("op_hs_once", op_hs - op0, 1);
    chk("res_hs_once", res_hs - res0, 1);
    if (last) begin
      chk("sum_latency", {acc_val, fsm_state}, {1'b1, ST_DONE});
      model_push();
    end else begin
      chk("back_idle", {in_ready, fsm_state}, {1'b1, ST_IDLE});
    end
  endtask

  task automatic collect(input int dly);
    exp_t e;
    chk("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_t'(exp_q[0]);
    in_val = 1'b1; in_last = 1'b1;
    in_op_1_re = 8'h11; in_op_1_im = 8'h22; in_op_2_re = 8'h33; in_op_2_im = 8'h44;
    for (int i = 0; i <= dly; i++) begin
      chk("done_flags", {in_ready, mult_op_val, mult_res_ready, acc_val}, 4'b0001);
      chk("acc_re", acc_re, e.re);
      chk("acc_im", acc_im, e.im);
      chk("acc_cnt", acc_cnt, e.cnt);
      chk("acc_ovf", acc_ovf, e.ovf);
      chk("acc16_re", b_acc_re, e.re16);
      chk("acc16_im", b_acc_im, e.im16);
      chk("acc16_cnt_ovf", {b_acc_val, b_acc_cnt, b_acc_ovf}, {1'b1, e.cnt, e.ovf16});
      acc_ready = (i == dly);
      @(negedge clk);
    end
    acc_ready = 1'b0; in_val = 1'b0; in_last = 1'b0;
    void'(exp_q.pop_front());
    chk("post_acc_state", {fsm_state, in_ready, acc_val}, {ST_IDLE, 1'b1, 1'b0});
    chk("post_acc_clear", {acc_re, acc_im, acc_cnt, acc_ovf}, '0);
    chk("post_acc16_clear", {b_acc_re, b_acc_im, b_acc_cnt, b_acc_ovf}, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] r0, r1, r2, r3;
    int nt;
    repeat (3) @(negedge clk);
    chk("rst_state", fsm_state, ST_IDLE);
    chk("rst_outs", {mult_op_val, mult_res_ready, acc_val, acc_ovf}, 4'b0000);
    chk("rst_acc", {acc_re, acc_im, acc_cnt}, '0);
    chk("rst_ops", {mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im}, '0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // single term: (3+4j)(1+2j) = -5+10j
    do_term(8'd3, 8'd4, 8'd1, 8'd2, 1'b1, 0, 0);
    collect(0);

    // two-term burst: adds (2+0j)(5+1j) = 10+2j -> 5+12j
    do_term(8'd3, 8'd4, 8'd1, 8'd2, 1'b0, 0, 0);
    do_term(8'd2, 8'd0, 8'd5, 8'd1, 1'b1, 0, 0);
    collect(0);

    // multiplier backpressure
    do_term(8'd100, 8'hF6, 8'h9C, 8'd7, 1'b1, 3, 4);
    collect(0);

    // output stall with a pending host request
    do_term(8'hFF, 8'd1, 8'd2, 8'hFE, 1'b1, 1, 0);
    collect(5);

    // software reset in WAIT abandons the burst
    do_term(8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 0, 0);
    in_op_1_re = 8'd5; in_op_1_im = 8'd6; in_op_2_re = 8'd7; in_op_2_im = 8'd8;
    in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0; mult_op_ready = 1'b1;
    @(negedge clk);
    mult_op_ready = 1'b0;
    chk("pre_swrst_state", fsm_state, ST_WAIT);
    sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0;
    model_clear();
    chk("swrst_state", {fsm_state, in_ready, mult_op_val, mult_res_ready}, {ST_IDLE, 3'b100});
    chk("swrst_acc", {acc_re, acc_im, acc_cnt, acc_ovf}, '0);
    chk("swrst_ops", {mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im}, '0);
    mult_res_val = 1'b1; mult_op_ready = 1'b1;
    mult_result_re = 16'h1234; mult_result_im = 16'h4321;
    @(negedge clk);
    mult_res_val = 1'b0; mult_op_ready = 1'b0;
    chk("stale_res_ignored", {fsm_state, acc_re, acc_cnt}, {ST_IDLE, 20'h0, 8'h0});

    // overflow: two products of 0x7F00 wrap the 16-bit accumulator
    do_term(8'h80, 8'd126, 8'h80, 8'h80, 1'b0, 0, 0);
    do_term(8'h80, 8'd126, 8'h80, 8'h80, 1'b1, 0, 0);
    collect(2);

    // random bursts
    for (int b = 0; b < 4; b++) begin
      nt = $urandom_range(1, 4);
      for (int t = 0; t < nt; t++) begin
        r0 = 8'($urandom_range(0, 255)); r1 = 8'($urandom_range(0, 255));
        r2 = 8'($urandom_range(0, 255)); r3 = 8'($urandom_range(0, 255));
        do_term(r0, r1, r2, r3, t == nt - 1, $urandom_range(0, 2), $urandom_range(0, 2));
      end
      collect($urandom_range(0, 2));
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
